multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle MIPS main control FSM. Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives the ALU `control_lines` encoding and the datapath mux selects and write enables.
- Consumes the ALU `zero_flag` to resolve branches.
- Sits between the instruction register (opcode/funct) and the shared datapath (PC, IR, A/B, ALUOut, MDR, register file, unified memory).

Parameters:
- SUPPORT_BNE, 1, 1 = opcode 0x05 decoded as bne; 0 = treated as illegal.
- HALT_ON_ILLEGAL, 0, 1 = illegal opcode/funct enters S_HALT until reset; 0 = skip the instruction and return to S_FETCH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], stable from the cycle after S_FETCH
- funct  in  6  IR[5:0]
- zero_flag  in  1  ALU zero output
- pc_en  out  1  PC write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = A, 10 = zero-extended shamt
- alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm << 2
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_control  out  4  ALU operation code
- instr_done  out  1  1-cycle pulse in the final state of each instruction
- illegal_op  out  1  1-cycle pulse on an undecodable instruction
- state  out  4  current state, for debug

Behaviour:
- Single clock `clk`; `reset` is synchronous, active-high.
- Reset: state <= S_FETCH at the clock edge. While reset = 1, pc_en, ir_write, mem_write, reg_write, instr_done and illegal_op are forced to 0. All other outputs show S_FETCH values.
- Outputs are Moore decodes of the state register, plus the funct/opcode/zero_flag terms listed below. No output registers.
- Unlisted outputs are 0 in every state; alu_control defaults to ADD.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, SLL 1000.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, HALT 12. Codes 13–15 go to FETCH.
- FETCH: ir_write = 1, pc_en = 1, alu_src_b = 01, ADD. Next state DECODE.
- DECODE: alu_src_b = 11, ADD (branch target precomputed into ALUOut). Next state by opcode:
  - 0x23 (lw) or 0x2B (sw) -> MEMADR
  - 0x00 -> EXEC
  - 0x04 (beq), or 0x05 (bne) when SUPPORT_BNE -> BRANCH
  - 0x08 (addi) -> ADDIEX
  - 0x02 (j) -> JUMP
  - anything else -> illegal
- MEMADR: alu_src_a = 01, alu_src_b = 10, ADD. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord = 1. Next state MEMWB.
- MEMWB: mem_to_reg = 1, reg_write = 1, instr_done = 1. Next state FETCH.
- MEMWR: iord = 1, mem_write = 1, instr_done = 1. Next state FETCH.
- EXEC: alu_src_b = 00. alu_src_a = 10 if funct = 0x00, else 01. alu_control by funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT, 0x00 SLL
  - Next state ALUWB.
  - Any other funct is illegal: reg_write is never asserted for that instruction.
- ALUWB: reg_dst = 1, reg_write = 1, instr_done = 1. Next state FETCH.
- BRANCH: alu_src_a = 01, alu_src_b = 00, SUB, pc_src = 01, instr_done = 1. pc_en = zero_flag for beq, ~zero_flag for bne. Next state FETCH.
- ADDIEX: alu_src_a = 01, alu_src_b = 10, ADD. Next state ADDIWB.
- ADDIWB: reg_write = 1, instr_done = 1. Next state FETCH.
- JUMP: pc_src = 10, pc_en = 1, instr_done = 1. Next state FETCH.
- Illegal handling (decided in DECODE or EXEC): illegal_op pulses for that one cycle; instr_done stays 0. Next state is FETCH, or HALT if HALT_ON_ILLEGAL.
- HALT: all enables 0. Stays in HALT until reset.
- Latencies in cycles, FETCH through final state inclusive: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2 (decode) or 3 (funct).
- Reset asserted mid-instruction: next state is FETCH; no write enable is asserted during the reset cycle.

Decomposition:
- Shared package `mips_pkg`:
  - ALU code constants.
  - Opcode and funct constants.
  - State enum (4-bit).
  - Mux select constants for alu_src_a, alu_src_b and pc_src.
- Sub-module `alu_decoder`: combinational funct -> {alu_control, is_shift, funct_valid}; reused by a future pipelined core.
- The FSM and output decode stay in this module.

Test Plan:
- Reset held 3 cycles, then released with opcode = 0x23 -> state sequence 0,1,2,3,4,0; reg_write = 1 and mem_to_reg = 1 only in cycle 5; instr_done pulses once.
- opcode 0x00, funct 0x22 -> EXEC shows alu_control = 0110, alu_src_a = 01; ALUWB has reg_dst = 1, reg_write = 1; 4 cycles total.
- funct 0x00 (sll) -> EXEC shows alu_control = 1000, alu_src_a = 10.
- beq with zero_flag = 1 -> pc_en = 1, pc_src = 01 in BRANCH; repeat with zero_flag = 0 -> pc_en = 0. bne inverts both results. With SUPPORT_BNE = 0, bne -> illegal_op pulse in DECODE.
- opcode 0x3F: HALT_ON_ILLEGAL = 0 -> illegal_op pulse, back to FETCH, no write enable asserted. HALT_ON_ILLEGAL = 1 -> state stays 12 for 20 cycles until reset.
- Reset asserted in MEMRD of a lw -> next state is 0; reg_write never asserted for that lw.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: ALU codes,
// opcode/funct values, FSM state encoding and datapath mux selects.
package mips_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  // Main control FSM states; codes 13-15 are unused
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  // ALU A operand select
  localparam logic [1:0] ASA_PC    = 2'b00;
  localparam logic [1:0] ASA_A     = 2'b01;
  localparam logic [1:0] ASA_SHAMT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ASB_B       = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder: ALU operation, shift flag and
// validity. Kept standalone so a pipelined core can reuse it.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_control,
  output logic       o_is_shift,
  output logic       o_funct_valid
);

  // Map funct to ALU op; unknown funct reports invalid and falls back to ADD
  always_comb begin
    o_alu_control = ALU_ADD;
    o_is_shift    = 1'b0;
    o_funct_valid = 1'b1;
    case (i_funct)
      F_ADD:   o_alu_control = ALU_ADD;
      F_SUB:   o_alu_control = ALU_SUB;
      F_AND:   o_alu_control = ALU_AND;
      F_OR:    o_alu_control = ALU_OR;
      F_NOR:   o_alu_control = ALU_NOR;
      F_SLT:   o_alu_control = ALU_SLT;
      F_SLL: begin
        o_alu_control = ALU_SLL;
        o_is_shift    = 1'b1;
      end
      default: o_funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM. Moore decode of the state register
// plus opcode/funct/zero_flag terms drives the shared datapath.
module multicycle_control
  import mips_pkg::*;
#(
  parameter bit SUPPORT_BNE     = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_control,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_dec_state;
  state_t     w_illegal_next;
  logic [3:0] w_alu_fn;
  logic       w_is_shift;
  logic       w_funct_valid;
  logic       w_op_legal;

  alu_decoder u_alu_decoder (
    .i_funct       (funct),
    .o_alu_control (w_alu_fn),
    .o_is_shift    (w_is_shift),
    .o_funct_valid (w_funct_valid)
  );

  assign w_illegal_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
  // While reset is held, outputs decode as FETCH regardless of the register
  assign w_dec_state    = reset ? S_FETCH : r_state;
  assign state          = r_state;

  // Opcode legality as seen in DECODE
  always_comb begin
    w_op_legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
      OP_BNE:  w_op_legal = SUPPORT_BNE;
      default: w_op_legal = 1'b0;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (!w_op_legal) w_next = w_illegal_next;
        else begin
          case (opcode)
            OP_LW, OP_SW:   w_next = S_MEMADR;
            OP_RTYPE:       w_next = S_EXEC;
            OP_BEQ, OP_BNE: w_next = S_BRANCH;
            OP_ADDI:        w_next = S_ADDIEX;
            OP_J:           w_next = S_JUMP;
            default:        w_next = w_illegal_next;
          endcase
        end
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = w_funct_valid ? S_ALUWB : w_illegal_next;
      S_ADDIEX: w_next = S_ADDIWB;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  // Output decode; write enables and pulses are suppressed during reset
  always_comb begin
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = ASA_PC;
    alu_src_b   = ASB_B;
    pc_src      = PCS_ALU;
    alu_control = ALU_ADD;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (w_dec_state)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_en     = 1'b1;
        alu_src_b = ASB_FOUR;
      end
      S_DECODE: begin
        alu_src_b  = ASB_IMM_SH2;
        illegal_op = ~w_op_legal;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = ASA_A;
        alu_src_b = ASB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        alu_src_a   = w_is_shift ? ASA_SHAMT : ASA_A;
        alu_control = w_alu_fn;
        illegal_op  = ~w_funct_valid;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = ASA_A;
        alu_control = ALU_SUB;
        pc_src      = PCS_ALUOUT;
        instr_done  = 1'b1;
        pc_en       = (opcode == OP_BNE) ? ~zero_flag : zero_flag;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PCS_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle vector table on the
// default configuration, plus directed sequences for reset-abort, the
// SUPPORT_BNE=0 decode and HALT_ON_ILLEGAL behaviour.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;

  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic [3:0] alu_control, state;
  logic       instr_done, illegal_op;

  logic       a_pc_en, a_iord, a_mem_write, a_ir_write, a_reg_dst, a_mem_to_reg, a_reg_write;
  logic [1:0] a_alu_src_a, a_alu_src_b, a_pc_src;
  logic [3:0] a_alu_control, a_state;
  logic       a_instr_done, a_illegal_op;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.SUPPORT_BNE(1'b1), .HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  multicycle_control #(.SUPPORT_BNE(1'b0), .HALT_ON_ILLEGAL(1'b1)) dut_alt (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
    .pc_en(a_pc_en), .iord(a_iord), .mem_write(a_mem_write), .ir_write(a_ir_write),
    .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .pc_src(a_pc_src),
    .alu_control(a_alu_control), .instr_done(a_instr_done), .illegal_op(a_illegal_op),
    .state(a_state)
  );

  // {pc_en,iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,asa,asb,pcs,alu,done,ill}
  wire [18:0] w_ctrl = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                        alu_src_a, alu_src_b, pc_src, alu_control, instr_done, illegal_op};
  // {pc_en,mem_write,ir_write,reg_write,instr_done,illegal_op}
  wire [5:0]  w_alt_en = {a_pc_en, a_mem_write, a_ir_write, a_reg_write, a_instr_done, a_illegal_op};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zf;
    logic [3:0]  st;
    logic [18:0] ctrl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic zf, input logic [3:0] st,
                     input logic pe, input logic io, input logic mw, input logic iw,
                     input logic rd, input logic mr, input logic rw,
                     input logic [1:0] asa, input logic [1:0] asb, input logic [1:0] pcs,
                     input logic [3:0] alu, input logic dn, input logic il);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.zf = zf; v.st = st;
    v.ctrl = {pe, io, mw, iw, rd, mr, rw, asa, asb, pcs, alu, dn, il};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn, input logic zf);
    @(negedge clk);
    reset = rst; opcode = op; funct = fn; zero_flag = zf;
    #1;
  endtask

  // Common FETCH / DECODE rows for the default instance
  task automatic add_fd(input logic [5:0] op, input logic [5:0] fn, input logic zf);
    add(0, op, fn, zf, 4'd0, 1,0,0,1,0,0,0, 2'b00, 2'b01, 2'b00, 4'b0010, 0, 0);
    add(0, op, fn, zf, 4'd1, 0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b00, 4'b0010, 0, 0);
  endtask

  task automatic add_branch(input logic [5:0] op, input logic zf, input logic pe);
    add_fd(op, 6'h00, zf);
    add(0, op, 6'h00, zf, 4'd8, pe,0,0,0,0,0,0, 2'b01, 2'b00, 2'b01, 4'b0110, 1, 0);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h23; funct = 6'h00; zero_flag = 1'b0;
    @(posedge clk);

    // Reset held: FETCH values, enables forced low
    for (int i = 0; i < 3; i++)
      add(1, 6'h23, 6'h00, 0, 4'd0, 0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b00, 4'b0010, 0, 0);
    // lw: 0,1,2,3,4
    add_fd(6'h23, 6'h00, 0);
    add(0, 6'h23, 6'h00, 0, 4'd2, 0,0,0,0,0,0,0, 2'b01, 2'b10, 2'b00, 4'b0010, 0, 0);
    add(0, 6'h23, 6'h00, 0, 4'd3, 0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'b0010, 0, 0);
    add(0, 6'h23, 6'h00, 0, 4'd4, 0,0,0,0,0,1,1, 2'b00, 2'b00, 2'b00, 4'b0010, 1, 0);
    // sub: 0,1,6,7
    add_fd(6'h00, 6'h22, 0);
    add(0, 6'h00, 6'h22, 0, 4'd6, 0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 4'b0110, 0, 0);
    add(0, 6'h00, 6'h22, 0, 4'd7, 0,0,0,0,1,0,1, 2'b00, 2'b00, 2'b00, 4'b0010, 1, 0);
    // sll: shamt on A, ALU SLL
    add_fd(6'h00, 6'h00, 0);
    add(0, 6'h00, 6'h00, 0, 4'd6, 0,0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, 4'b1000, 0, 0);
    add(0, 6'h00, 6'h00, 0, 4'd7, 0,0,0,0,1,0,1, 2'b00, 2'b00, 2'b00, 4'b0010, 1, 0);
    // beq / bne with both zero_flag values
    add_branch(6'h04, 1, 1);
    add_branch(6'h04, 0, 0);
    add_branch(6'h05, 1, 0);
    add_branch(6'h05, 0, 1);
    // sw: 0,1,2,5
    add_fd(6'h2B, 6'h00, 0);
    add(0, 6'h2B, 6'h00, 0, 4'd2, 0,0,0,0,0,0,0, 2'b01, 2'b10, 2'b00, 4'b0010, 0, 0);
    add(0, 6'h2B, 6'h00, 0, 4'd5, 0,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'b0010, 1, 0);
    // addi: 0,1,9,10
    add_fd(6'h08, 6'h00, 0);
    add(0, 6'h08, 6'h00, 0, 4'd9, 0,0,0,0,0,0,0, 2'b01, 2'b10, 2'b00, 4'b0010, 0, 0);
    add(0, 6'h08, 6'h00, 0, 4'd10, 0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 4'b0010, 1, 0);
    // j: 0,1,11
    add_fd(6'h02, 6'h00, 0);
    add(0, 6'h02, 6'h00, 0, 4'd11, 1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 4'b0010, 1, 0);
    // illegal opcode 0x3F: illegal pulse in DECODE, no done
    add(0, 6'h3F, 6'h00, 0, 4'd0, 1,0,0,1,0,0,0, 2'b00, 2'b01, 2'b00, 4'b0010, 0, 0);
    add(0, 6'h3F, 6'h00, 0, 4'd1, 0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b00, 4'b0010, 0, 1);
    // illegal funct 0x3F: illegal pulse in EXEC, no reg_write
    add_fd(6'h00, 6'h3F, 0);
    add(0, 6'h00, 6'h3F, 0, 4'd6, 0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 4'b0010, 0, 1);
    // back in FETCH
    add(0, 6'h23, 6'h00, 0, 4'd0, 1,0,0,1,0,0,0, 2'b00, 2'b01, 2'b00, 4'b0010, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].zf);
      chk($sformatf("row%0d state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("row%0d ctrl", i),  32'(w_ctrl), 32'(vecs[i].ctrl));
    end

    // Reset during MEMRD of a lw aborts the instruction
    step(1, 6'h23, 6'h00, 0);
    for (int c = 0; c < 4; c++) begin
      step(0, 6'h23, 6'h00, 0);
      chk($sformatf("abort lw state c%0d", c), 32'(state), c);
      chk($sformatf("abort lw reg_write c%0d", c), 32'(reg_write), 32'd0);
    end
    step(1, 6'h23, 6'h00, 0);
    chk("abort reset-cycle enables", 32'({pc_en, ir_write, mem_write, reg_write, instr_done}), 32'd0);
    chk("abort reset-cycle iord", 32'(iord), 32'd0);
    step(0, 6'h23, 6'h00, 0);
    chk("abort next state", 32'(state), 32'd0);
    chk("abort mem_to_reg", 32'(mem_to_reg), 32'd0);

    // SUPPORT_BNE=0: bne is illegal in DECODE, then HALT
    step(1, 6'h05, 6'h00, 1);
    step(0, 6'h05, 6'h00, 1);
    chk("alt bne fetch state", 32'(a_state), 32'd0);
    step(0, 6'h05, 6'h00, 1);
    chk("alt bne decode state", 32'(a_state), 32'd1);
    chk("alt bne illegal_op", 32'(a_illegal_op), 32'd1);
    chk("alt bne instr_done", 32'(a_instr_done), 32'd0);
    step(0, 6'h05, 6'h00, 1);
    chk("alt bne halt state", 32'(a_state), 32'd12);
    chk("alt bne halt enables", 32'(w_alt_en), 32'd0);

    // HALT_ON_ILLEGAL=1 with opcode 0x3F: HALT persists until reset
    step(1, 6'h3F, 6'h00, 0);
    step(0, 6'h3F, 6'h00, 0);
    step(0, 6'h3F, 6'h00, 0);
    chk("alt 3F decode illegal_op", 32'(a_illegal_op), 32'd1);
    for (int c = 0; c < 20; c++) begin
      step(0, 6'h3F, 6'h00, 0);
      chk($sformatf("alt halt state c%0d", c), 32'(a_state), 32'd12);
      chk($sformatf("alt halt enables c%0d", c), 32'(w_alt_en), 32'd0);
    end
    step(1, 6'h23, 6'h00, 0);
    step(0, 6'h23, 6'h00, 0);
    chk("alt post-halt state", 32'(a_state), 32'd0);
    chk("alt post-halt ir_write", 32'(a_ir_write), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
